// File: rtl/npc_unit.sv
`default_nettype none
// ============================================================================
// Module      : npc_unit
// Description : Next-PC generator. Selects the next program counter from
//               exception, branch, return, jump and sequential sources,
//               keeps a pending-redirect latch so redirects raised while the
//               pipeline is stalled are replayed afterwards, and (optionally)
//               a circular return-address stack.
//               Optional feature macro: NPC_RAS_EN (return-address stack).
// Ports       : clk, rst_n (async, active low)
//               cur_pc, stall, exc_req/exc_vector, br_taken/br_target,
//               jmp, call, ret, jmp_target          -> inputs
//               nxt_pc, redirect, misalign, ras_miss, ras_count -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module npc_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                RAS_DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          cur_pc,
    input  logic                       stall,
    input  logic                       exc_req,
    input  logic [ADDR_W-1:0]          exc_vector,
    input  logic                       br_taken,
    input  logic [ADDR_W-1:0]          br_target,
    input  logic                       jmp,
    input  logic                       call,
    input  logic                       ret,
    input  logic [ADDR_W-1:0]          jmp_target,
    output logic [ADDR_W-1:0]          nxt_pc,
    output logic                       redirect,
    output logic                       misalign,
    output logic                       ras_miss,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    localparam int                c_PTR_W    = $clog2(RAS_DEPTH);
    localparam int                c_CNT_W    = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_FOUR     = ADDR_W'(4);
    // Request priority codes, used to decide whether a request raised during
    // a stall may replace the one already latched.
    localparam logic [1:0]        c_PRIO_JMP = 2'd0;
    localparam logic [1:0]        c_PRIO_RET = 2'd1;
    localparam logic [1:0]        c_PRIO_BR  = 2'd2;
    localparam logic [1:0]        c_PRIO_EXC = 2'd3;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_raw_tgt;
    logic [ADDR_W-1:0] w_fin_tgt;
    logic [1:0]        w_sel_prio;
    logic              w_any_req;
    logic              w_jmp_req;
    logic              w_ras_en;
    logic              w_ras_empty;
    logic [ADDR_W-1:0] w_top;
    logic              w_ras_op_en;

    logic              r_pend_valid_q, w_pend_valid_d;
    logic [ADDR_W-1:0] r_pend_addr_q,  w_pend_addr_d;
    logic [1:0]        r_pend_prio_q,  w_pend_prio_d;

    assign w_seq = cur_pc + c_FOUR;

`ifdef NPC_RAS_EN
    logic [ADDR_W-1:0]  r_stack_q [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_sp_q,  w_sp_d;      // next free slot
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RAS_DEPTH);

    assign w_ras_en    = 1'b1;
    assign w_jmp_req   = jmp;
    assign w_top_idx   = r_sp_q - 1'b1;
    assign w_top       = r_stack_q[w_top_idx];
    assign w_ras_empty = (r_cnt_q == '0);
    assign ras_count   = r_cnt_q;

    always_comb begin
        w_sp_d   = r_sp_q;
        w_cnt_d  = r_cnt_q;
        w_wr_en  = 1'b0;
        w_wr_idx = r_sp_q;
        if (w_ras_op_en) begin
            if (ret && jmp && call && !w_ras_empty) begin
                // Return and call together: swap the top in place.
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end else if (jmp && call) begin
                // A full stack wraps the pointer onto the oldest entry.
                w_wr_en = 1'b1;
                w_sp_d  = r_sp_q + 1'b1;
                if (r_cnt_q != c_CNT_MAX) begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end else if (ret && !w_ras_empty) begin
                w_sp_d  = r_sp_q - 1'b1;
                w_cnt_d = r_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            r_sp_q  <= w_sp_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    // Entry storage needs no reset: only slots below ras_count are ever read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack_q[w_wr_idx] <= w_seq;
        end
    end
`else
    // Without a stack a call is just a jump and every return falls back to
    // jmp_target (an always-empty stack, but never reported as a miss).
    assign w_ras_en    = 1'b0;
    assign w_jmp_req   = jmp | call;
    assign w_top       = '0;
    assign w_ras_empty = 1'b1;
    assign ras_count   = '0;
`endif

    // Highest-priority request this cycle, before alignment.
    always_comb begin
        w_raw_tgt  = w_seq;
        w_sel_prio = c_PRIO_JMP;
        w_any_req  = 1'b1;
        if (exc_req) begin
            w_raw_tgt  = exc_vector;
            w_sel_prio = c_PRIO_EXC;
        end else if (br_taken) begin
            w_raw_tgt  = br_target;
            w_sel_prio = c_PRIO_BR;
        end else if (ret) begin
            w_raw_tgt  = w_ras_empty ? jmp_target : w_top;
            w_sel_prio = c_PRIO_RET;
        end else if (w_jmp_req) begin
            w_raw_tgt  = jmp_target;
            w_sel_prio = c_PRIO_JMP;
        end else begin
            w_any_req  = 1'b0;
        end
    end

    always_comb begin
        nxt_pc         = w_seq;
        redirect       = 1'b0;
        misalign       = 1'b0;
        ras_miss       = 1'b0;
        w_ras_op_en    = 1'b0;
        w_fin_tgt      = w_raw_tgt;
        w_pend_valid_d = r_pend_valid_q;
        w_pend_addr_d  = r_pend_addr_q;
        w_pend_prio_d  = r_pend_prio_q;
        if (!rst_n) begin
            nxt_pc = RESET_VECTOR;
        end else if (stall) begin
            nxt_pc = cur_pc;
            // The raw target is latched so misalign is reported on replay.
            if (w_any_req && (!r_pend_valid_q || (w_sel_prio > r_pend_prio_q))) begin
                w_pend_valid_d = 1'b1;
                w_pend_addr_d  = w_raw_tgt;
                w_pend_prio_d  = w_sel_prio;
            end
        end else if (r_pend_valid_q) begin
            // Pipeline was flushed: only an exception can pre-empt the replay.
            w_fin_tgt      = exc_req ? exc_vector : r_pend_addr_q;
            nxt_pc         = {w_fin_tgt[ADDR_W-1:2], 2'b00};
            misalign       = |w_fin_tgt[1:0];
            redirect       = 1'b1;
            w_pend_valid_d = 1'b0;
        end else if (w_any_req) begin
            nxt_pc      = {w_raw_tgt[ADDR_W-1:2], 2'b00};
            misalign    = |w_raw_tgt[1:0];
            redirect    = 1'b1;
            w_ras_op_en = !exc_req && !br_taken;
            ras_miss    = w_ras_en && !exc_req && !br_taken && ret && w_ras_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid_q <= 1'b0;
            r_pend_addr_q  <= '0;
            r_pend_prio_q  <= c_PRIO_JMP;
        end else begin
            r_pend_valid_q <= w_pend_valid_d;
            r_pend_addr_q  <= w_pend_addr_d;
            r_pend_prio_q  <= w_pend_prio_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_unit
// Description : Self-checking bench for npc_unit. Directed vectors with
//               hand-computed expectations, applied in sequence so stall /
//               pending-redirect state carries between entries. Stack
//               sequences are included when NPC_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_unit;

`ifdef NPC_RAS_EN
    localparam bit c_RAS = 1'b1;
`else
    localparam bit c_RAS = 1'b0;
`endif

    // Request flag encodings: {exc, br, ret, jmp, call}
    localparam logic [4:0] c_NONE = 5'b00000;
    localparam logic [4:0] c_EXC  = 5'b10000;
    localparam logic [4:0] c_BR   = 5'b01000;
    localparam logic [4:0] c_RET  = 5'b00100;
    localparam logic [4:0] c_JMP  = 5'b00010;
    localparam logic [4:0] c_CALL = 5'b00011;

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic [4:0]  req;
        logic [31:0] ev;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] e_npc;
        logic        e_red;
        logic        e_mis;
        logic        e_miss;
        logic [3:0]  e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cur_pc, exc_vector, br_target, jmp_target, nxt_pc;
    logic        stall, exc_req, br_taken, jmp, call, ret;
    logic        redirect, misalign, ras_miss;
    logic [3:0]  ras_count;

    int n_tests = 0;
    int n_fail  = 0;

    npc_unit #(
        .ADDR_W      (32),
        .RAS_DEPTH   (8),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_pc    (cur_pc),
        .stall     (stall),
        .exc_req   (exc_req),
        .exc_vector(exc_vector),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp       (jmp),
        .call      (call),
        .ret       (ret),
        .jmp_target(jmp_target),
        .nxt_pc    (nxt_pc),
        .redirect  (redirect),
        .misalign  (misalign),
        .ras_miss  (ras_miss),
        .ras_count (ras_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] pc, input logic st, input logic [4:0] rq,
                                input logic [31:0] ev, input logic [31:0] bt, input logic [31:0] jt,
                                input logic [31:0] e_npc, input logic e_red, input logic e_mis,
                                input logic e_miss, input logic [3:0] e_cnt);
        vec_t v;
        v.pc = pc; v.stall = st; v.req = rq; v.ev = ev; v.bt = bt; v.jt = jt;
        v.e_npc = e_npc; v.e_red = e_red; v.e_mis = e_mis; v.e_miss = e_miss; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cur_pc     = v.pc;
        stall      = v.stall;
        exc_req    = v.req[4];
        br_taken   = v.req[3];
        ret        = v.req[2];
        jmp        = v.req[1];
        call       = v.req[0];
        exc_vector = v.ev;
        br_target  = v.bt;
        jmp_target = v.jt;
    endtask

    // Called just after a falling edge; checks the combinational outputs,
    // then lets one rising edge update state.
    task automatic apply(input vec_t v, input string nm);
        drive(v);
        #1;
        chk({nm, ".nxt_pc"},    nxt_pc,            v.e_npc);
        chk({nm, ".redirect"},  {31'b0, redirect}, {31'b0, v.e_red});
        chk({nm, ".misalign"},  {31'b0, misalign}, {31'b0, v.e_mis});
        chk({nm, ".ras_miss"},  {31'b0, ras_miss}, {31'b0, v.e_miss});
        chk({nm, ".ras_count"}, {28'b0, ras_count}, {28'b0, v.e_cnt});
        @(negedge clk);
    endtask

    vec_t tbl [$];

    initial begin
        // ---------------- reset overrides everything ----------------
        rst_n = 1'b0;
        drive(mk(32'h100, 1'b0, c_EXC, 32'h83, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("rst.nxt_pc",    nxt_pc,            32'h0);
        chk("rst.redirect",  {31'b0, redirect}, 32'h0);
        chk("rst.misalign",  {31'b0, misalign}, 32'h0);
        chk("rst.ras_count", {28'b0, ras_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed sequence table ----------------
        //          pc           st  req     ev         bt          jt          e_npc       red mis miss cnt
        tbl.push_back(mk(32'h0,        0, c_NONE, 0,         0,          0,          32'h4,      0, 0, 0, 0));
        tbl.push_back(mk(32'hFFFF_FFFC,0, c_NONE, 0,         0,          0,          32'h0,      0, 0, 0, 0));
        tbl.push_back(mk(32'h100,      0, c_EXC|c_BR, 32'h80, 32'h200,   0,          32'h80,     1, 0, 0, 0));
        tbl.push_back(mk(32'h104,      0, c_BR|c_RET|c_JMP, 0, 32'h200,  32'h300,    32'h200,    1, 0, 0, 0));
        tbl.push_back(mk(32'h108,      0, c_RET,  0,         0,          32'h500,    32'h500,    1, 0, c_RAS, 0));
        tbl.push_back(mk(32'h10C,      0, c_JMP,  0,         0,          32'h1003,   32'h1000,   1, 1, 0, 0));
        // stall with branch in first cycle, lower-priority jmp later ignored
        tbl.push_back(mk(32'h200,      1, c_BR,   0,         32'h400,    0,          32'h200,    0, 0, 0, 0));
        tbl.push_back(mk(32'h200,      1, c_NONE, 0,         0,          0,          32'h200,    0, 0, 0, 0));
        tbl.push_back(mk(32'h200,      1, c_JMP,  0,         0,          32'h600,    32'h200,    0, 0, 0, 0));
        tbl.push_back(mk(32'h200,      0, c_JMP,  0,         0,          32'h700,    32'h400,    1, 0, 0, 0));
        tbl.push_back(mk(32'h400,      0, c_NONE, 0,         0,          0,          32'h404,    0, 0, 0, 0));
        // later higher-priority exception overwrites latched jmp
        tbl.push_back(mk(32'h500,      1, c_JMP,  0,         0,          32'h800,    32'h500,    0, 0, 0, 0));
        tbl.push_back(mk(32'h500,      1, c_EXC,  32'h90,    0,          0,          32'h500,    0, 0, 0, 0));
        tbl.push_back(mk(32'h500,      0, c_NONE, 0,         0,          0,          32'h90,     1, 0, 0, 0));
        // exception in the replay cycle wins over the latch
        tbl.push_back(mk(32'h600,      1, c_BR,   0,         32'h1001,   0,          32'h600,    0, 0, 0, 0));
        tbl.push_back(mk(32'h600,      0, c_EXC,  32'hC0,    0,          0,          32'hC0,     1, 0, 0, 0));
        tbl.push_back(mk(32'h604,      0, c_NONE, 0,         0,          0,          32'h608,    0, 0, 0, 0));
        // misaligned target latched during stall, flagged on replay
        tbl.push_back(mk(32'h700,      1, c_BR,   0,         32'h1002,   0,          32'h700,    0, 0, 0, 0));
        tbl.push_back(mk(32'h700,      0, c_NONE, 0,         0,          0,          32'h1000,   1, 1, 0, 0));
        // call then ret
        tbl.push_back(mk(32'h10,       0, c_CALL, 0,         0,          32'h1000,   32'h1000,   1, 0, 0, 0));
        tbl.push_back(mk(32'h1000,     0, c_RET,  0,         0,          32'h500,    c_RAS ? 32'h14 : 32'h500, 1, 0, 0, {3'b0, c_RAS}));
        tbl.push_back(mk(32'h500,      0, c_EXC,  32'h83,    0,          0,          32'h80,     1, 1, 0, 0));
        tbl.push_back(mk(32'h80,       0, c_NONE, 0,         0,          0,          32'h84,     0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // ---------------- reset mid-operation drops pending ----------------
        apply(mk(32'h20, 0, c_CALL, 0, 0, 32'h2000, 32'h2000, 1, 0, 0, 0), "mr.call");
        apply(mk(32'h2000, 1, c_BR, 0, 32'hA00, 0, 32'h2000, 0, 0, 0, {3'b0, c_RAS}), "mr.stall");
        rst_n = 1'b0;
        #1;
        chk("mr.rst.nxt_pc",   nxt_pc,             32'h0);
        chk("mr.rst.redirect", {31'b0, redirect},  32'h0);
        chk("mr.rst.count",    {28'b0, ras_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(32'h2000, 0, c_NONE, 0, 0, 0, 32'h2004, 0, 0, 0, 0), "mr.after");

`ifdef NPC_RAS_EN
        // 9 calls overflow the 8-entry stack; oldest (0x4) is lost
        for (int i = 0; i < 9; i++)
            apply(mk(32'(i * 4), 0, c_CALL, 0, 0, 32'h1000 + 32'(i * 16), 32'h1000 + 32'(i * 16),
                     1, 0, 0, (i < 8) ? 4'(i) : 4'd8), $sformatf("ovf.call%0d", i));
        for (int k = 0; k < 8; k++)
            apply(mk(32'h3000, 0, c_RET, 0, 0, 32'h500, 32'h24 - 32'(k * 4), 1, 0, 0, 4'(8 - k)),
                  $sformatf("ovf.ret%0d", k));
        apply(mk(32'h3000, 0, c_RET, 0, 0, 32'h500, 32'h500, 1, 0, 1, 0), "ovf.empty");
        // call+ret with non-empty stack swaps the top
        apply(mk(32'h40, 0, c_CALL, 0, 0, 32'h4000, 32'h4000, 1, 0, 0, 0), "cr.call");
        apply(mk(32'h60, 0, c_CALL | c_RET, 0, 0, 32'h4100, 32'h44, 1, 0, 0, 1), "cr.swap");
        apply(mk(32'h4100, 0, c_RET, 0, 0, 32'h500, 32'h64, 1, 0, 0, 1), "cr.ret");
        // call+ret with empty stack: miss and push
        apply(mk(32'h80, 0, c_CALL | c_RET, 0, 0, 32'h3000, 32'h3000, 1, 0, 1, 0), "cr.empty");
        apply(mk(32'h3000, 0, c_RET, 0, 0, 32'h500, 32'h84, 1, 0, 0, 1), "cr.ret2");
        // no push during stall; branch beats call for stack update
        apply(mk(32'h50, 1, c_CALL, 0, 0, 32'h900, 32'h50, 0, 0, 0, 0), "st.call");
        apply(mk(32'h50, 0, c_NONE, 0, 0, 0, 32'h900, 1, 0, 0, 0), "st.replay");
        apply(mk(32'h900, 0, c_BR | c_CALL, 0, 32'hB00, 32'hC00, 32'hB00, 1, 0, 0, 0), "st.brcall");
        apply(mk(32'hB00, 0, c_NONE, 0, 0, 0, 32'hB04, 0, 0, 0, 0), "st.after");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Generates the next program counter that the PC register samples on the falling edge of clk.
- Consumes cur_pc and the control-flow requests from decode and execute.
- Holds a return-address stack and a pending-redirect latch, so redirects raised during a stall are not lost.
- All internal state updates on the rising edge of clk. nxt_pc is combinational from state and inputs, and is stable before the falling edge.

Parameters:
- ADDR_W, 32, width of every address.
- RAS_DEPTH, 8, return-address stack entries; power of two, minimum 2.
- RESET_VECTOR, 32'h0000_0000, nxt_pc value while reset is asserted.

Ports:
- clk  input  1  system clock; state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cur_pc  input  ADDR_W  current PC from the PC register.
- stall  input  1  pipeline hold; the PC must not advance.
- exc_req  input  1  exception redirect request.
- exc_vector  input  ADDR_W  exception handler address.
- br_taken  input  1  resolved taken branch from execute.
- br_target  input  ADDR_W  branch target.
- jmp  input  1  unconditional jump (includes call).
- call  input  1  jump that also pushes the return address; valid only with jmp.
- ret  input  1  return; pops the stack.
- jmp_target  input  ADDR_W  decoded or register jump target; also the fallback for ret.
- nxt_pc  output  ADDR_W  next PC for the PC register.
- redirect  output  1  nxt_pc differs from the sequential path this cycle.
- misalign  output  1  selected target had nonzero bits [1:0].
- ras_miss  output  1  ret was served with the stack empty.
- ras_count  output  $clog2(RAS_DEPTH)+1  number of valid stack entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - stack pointer = 0, ras_count = 0, pending_valid = 0, pending_addr = 0.
  - nxt_pc = RESET_VECTOR; redirect = misalign = ras_miss = 0.
- Source priority, highest first: exc_req > br_taken > ret > jmp > sequential.
  - sequential = cur_pc + 4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Target alignment: the selected target has bits [1:0] forced to 0 on nxt_pc; misalign = 1 if they were nonzero.
- Stall = 1:
  - nxt_pc = cur_pc; redirect = 0.
  - Any request raised during the stall is latched into pending_addr at posedge; pending_valid = 1.
  - A later, higher-priority request overwrites the latch; a lower-priority one is ignored.
  - No stack push or pop happens during a stall.
- Stall = 0 with pending_valid = 1:
  - An exc_req this cycle wins; otherwise nxt_pc = pending_addr.
  - redirect = 1; pending_valid clears at the next posedge.
  - New br, jmp and ret requests in this cycle are dropped (the pipeline has been flushed).
- Stall = 0, no pending redirect: nxt_pc = highest-priority source; redirect = 1 for any non-sequential source.
- Return-address stack (circular buffer, updates at posedge, only when stall = 0 and no higher-priority exc_req or br_taken):
  - call&jmp pushes cur_pc+4.
  - When full, a push overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - ret with ras_count > 0: target = top entry; pop; ras_count decrements.
  - ret with ras_count = 0: target = jmp_target; ras_miss = 1 for that cycle.
  - ret and call in the same cycle: target = top entry, and the top is replaced with cur_pc+4; ras_count unchanged. If the stack is empty, ras_miss = 1 and the push occurs.
- exc_req does not modify the stack.
- Reset deasserted mid-operation: state restarts from the reset values; no pending redirect survives.

Optional Feature:
- NPC_RAS_EN defined: return-address stack present, as described above.
- NPC_RAS_EN undefined:
  - No stack storage.
  - ret always uses jmp_target; call acts as a plain jmp.
  - ras_miss and ras_count are tied to 0.

Test Plan:
- Reset release with cur_pc=0, no requests -> nxt_pc=4, redirect=0. With cur_pc=32'hFFFF_FFFC -> nxt_pc=0.
- cur_pc=0x100, exc_req=1 vector 0x80, plus br_taken target 0x200 -> nxt_pc=0x80, redirect=1, ras_count unchanged.
- stall=1 for 3 cycles with br_taken target 0x400 in cycle 1 -> nxt_pc=cur_pc throughout the stall. First unstalled cycle: nxt_pc=0x400, redirect=1. Next cycle: sequential.
- Calls at pc 0x10, 0x20, 0x30 (targets 0x1000 etc.), then three rets -> ret targets 0x34, 0x24, 0x14; ras_count goes 3,2,1,0. A fourth ret with jmp_target 0x500 -> nxt_pc=0x500, ras_miss=1.
- RAS_DEPTH=8: 9 calls at pc 0x0..0x20, then 8 rets -> return addresses 0x24 down to 0x8; the oldest (0x4) is lost; ras_count saturates at 8.
- jmp_target=0x1003 -> nxt_pc=0x1000, misalign=1. Simultaneous call+ret with top 0x44 at pc 0x60 -> nxt_pc=0x44, top becomes 0x64, ras_count unchanged.
